// File: rtl/icache_direct.sv
// icache_direct: direct-mapped, one-word-per-line instruction cache between IF and the memory controller.
// Ports: clk, rst (sync, active-high), rdy (global enable, freezes all state when low), clr_i (flush);
//   IF side:  pcEn_i/pc_i request, instRdy_o/inst_o response pulse, busy_o high while a miss is outstanding;
//   mem side: ifEn_o/ifAddr_o word fetch request, ifRdy_i/ifData_i one-cycle response.
// Optional: define ICACHE_STAT_EN to add hitCnt_o/missCnt_o hit and miss-entry counters.
module icache_direct #(
    parameter int ADDR_W  = 32,
    parameter int INDEX_W = 7,
    parameter int TAG_W   = ADDR_W - INDEX_W - 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clr_i,
    input  logic              pcEn_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              instRdy_o,
    output logic [31:0]       inst_o,
    output logic              busy_o,
    output logic              ifEn_o,
    output logic [ADDR_W-1:0] ifAddr_o,
    input  logic              ifRdy_i,
    input  logic [31:0]       ifData_i
`ifdef ICACHE_STAT_EN
    ,
    output logic [31:0]       hitCnt_o,
    output logic [31:0]       missCnt_o
`endif
);
    localparam int LINES = 1 << INDEX_W;

    typedef enum logic {IDLE, MISS} state_t;

    state_t              r_state, w_state_nxt;
    logic                r_inst_rdy, w_inst_rdy_nxt;
    logic [31:0]         r_inst, w_inst_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_if_en, w_if_en_nxt;
    logic [ADDR_W-1:0]   r_if_addr, w_if_addr_nxt;
    logic [LINES-1:0]    r_valid;
    logic [TAG_W-1:0]    r_tag [LINES];
    logic [31:0]         r_data [LINES];

    logic [INDEX_W-1:0]  w_idx, w_fill_idx;
    logic [TAG_W-1:0]    w_tag, w_fill_tag;
    logic                w_hit, w_fill, w_accept;

    assign w_idx      = pc_i[INDEX_W+1:2];
    assign w_tag      = pc_i[ADDR_W-1:INDEX_W+2];
    assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    // ifAddr is held at the miss address for the whole MISS, so it doubles as the fill address.
    assign w_fill_idx = r_if_addr[INDEX_W+1:2];
    assign w_fill_tag = r_if_addr[ADDR_W-1:INDEX_W+2];
    assign w_fill     = rdy && !clr_i && (r_state == MISS) && ifRdy_i;
    assign w_accept   = rdy && !clr_i && (r_state == IDLE) && pcEn_i;

    assign instRdy_o = r_inst_rdy;
    assign inst_o    = r_inst;
    assign busy_o    = r_busy;
    assign ifEn_o    = r_if_en;
    assign ifAddr_o  = r_if_addr;

    always_comb begin
        w_state_nxt    = r_state;
        w_inst_rdy_nxt = 1'b0;
        w_inst_nxt     = r_inst;
        w_busy_nxt     = r_busy;
        w_if_en_nxt    = r_if_en;
        w_if_addr_nxt  = r_if_addr;
        if (clr_i) begin
            w_state_nxt = IDLE;
            w_busy_nxt  = 1'b0;
            w_if_en_nxt = 1'b0;
        end else if (r_state == IDLE) begin
            if (pcEn_i && w_hit) begin
                w_inst_rdy_nxt = 1'b1;
                w_inst_nxt     = r_data[w_idx];
            end else if (pcEn_i) begin
                w_state_nxt   = MISS;
                w_busy_nxt    = 1'b1;
                w_if_en_nxt   = 1'b1;
                w_if_addr_nxt = pc_i;
            end
        end else if (ifRdy_i) begin
            w_state_nxt    = IDLE;
            w_inst_rdy_nxt = 1'b1;
            w_inst_nxt     = ifData_i;
            w_busy_nxt     = 1'b0;
            w_if_en_nxt    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_inst_rdy <= 1'b0;
            r_inst     <= '0;
            r_busy     <= 1'b0;
            r_if_en    <= 1'b0;
            r_if_addr  <= '0;
            r_valid    <= '0;
        end else if (rdy) begin
            r_state    <= w_state_nxt;
            r_inst_rdy <= w_inst_rdy_nxt;
            r_inst     <= w_inst_nxt;
            r_busy     <= w_busy_nxt;
            r_if_en    <= w_if_en_nxt;
            r_if_addr  <= w_if_addr_nxt;
            if (w_fill) r_valid[w_fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_tag[w_fill_idx]  <= w_fill_tag;
            r_data[w_fill_idx] <= ifData_i;
        end
    end

`ifdef ICACHE_STAT_EN
    logic [31:0] r_hit_cnt, r_miss_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (w_accept) begin
            r_hit_cnt  <= w_hit ? r_hit_cnt + 32'd1 : r_hit_cnt;
            r_miss_cnt <= w_hit ? r_miss_cnt : r_miss_cnt + 32'd1;
        end
    end

    assign hitCnt_o  = r_hit_cnt;
    assign missCnt_o = r_miss_cnt;
`endif
endmodule
